// File: rtl/seq_det_pkg.sv
// Shared types for the 1001 sequence-detector scheduler: FSM states,
// detector state encodings and the hit-counter width.
package seq_det_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // Each state is named after the suffix of the pattern matched so far.
  typedef enum logic [2:0] {
    DET_S0    = 3'd0,
    DET_S1    = 3'd1,
    DET_S10   = 3'd2,
    DET_S100  = 3'd3,
    DET_S1001 = 3'd4
  } det_state_t;

endpackage

// File: rtl/seq_det_sched_if.sv
// Requester-side bus of the scheduler: request levels and words in,
// grant / done pulse / result out.
interface seq_det_sched_if
  import seq_det_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 8
);

  logic [NCH-1:0]          req;
  logic [NCH-1:0][DW-1:0]  data;
  logic [NCH-1:0]          gnt;
  logic [NCH-1:0]          ack;
  logic [CNT_W-1:0]        res_cnt;
  logic [$clog2(NCH)-1:0]  res_ch;
  logic                    busy;

  modport master (
    output req, data,
    input  gnt, ack, res_cnt, res_ch, busy
  );

  modport slave (
    input  req, data,
    output gnt, ack, res_cnt, res_ch, busy
  );

endinterface

// File: rtl/seq_det_1001.sv
// Serial Moore detector for the pattern 1001, overlapping matches allowed.
// z is high only while the detector sits in the match state.
module seq_det_1001
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic w,
  output logic z
);

  det_state_t cur, nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cur <= DET_S0;
    else if (clr) cur <= DET_S0;
    else          cur <= nxt;
  end

  // After a match the trailing 1 is reused as the leading 1 of the next hit.
  always_comb begin
    nxt = cur;
    case (cur)
      DET_S0:    nxt = w ? DET_S1 : DET_S0;
      DET_S1:    nxt = w ? DET_S1 : DET_S10;
      DET_S10:   nxt = w ? DET_S1 : DET_S100;
      DET_S100:  nxt = w ? DET_S1001 : DET_S0;
      DET_S1001: nxt = w ? DET_S1 : DET_S10;
      default:   nxt = DET_S0;
    endcase
  end

  assign z = (cur == DET_S1001);

endmodule

// File: rtl/seq_det_sched.sv
// Shares one 1001 detector among NCH requesters, one word per transaction.
// Define SEQ_DET_SCHED_RR_EN for round-robin arbitration; default is fixed priority.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  seq_det_sched_if.slave bus
);

  localparam int CHW = $clog2(NCH);
  localparam int BCW = $clog2(DW + 1);

  sched_state_t     state, state_nxt;
  logic [DW-1:0]    word;
  logic [BCW-1:0]   bit_cnt;
  logic [NCH-1:0]   gnt_q;
  logic [CHW-1:0]   ch_q;
  logic [CNT_W-1:0] cnt_q;
  logic             win_vld;
  logic [CHW-1:0]   win_idx;
  logic             grant;
  logic             det_clr;
  logic             det_z;

`ifdef SEQ_DET_SCHED_RR_EN
  localparam int SW = CHW + 1;
  logic [CHW-1:0] ptr;
  logic [SW-1:0]  cand;

  // Search starts at ptr and wraps; the first requester found wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = {1'b0, ptr} + SW'(k);
      if (cand >= SW'(NCH)) cand = cand - SW'(NCH);
      if (!win_vld && bus.req[cand[CHW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[CHW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       ptr <= '0;
    else if (grant) ptr <= (win_idx == CHW'(NCH - 1)) ? '0 : win_idx + CHW'(1);
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!win_vld && bus.req[k]) begin
        win_vld = 1'b1;
        win_idx = CHW'(k);
      end
    end
  end
`endif

  assign grant = (state == IDLE) && win_vld;

  // The first SHIFT cycle holds the detector cleared, so the word occupies
  // the next DW cycles and ack lands DW+2 edges after the grant edge.
  always_comb begin
    state_nxt = state;
    det_clr   = 1'b0;
    case (state)
      IDLE: begin
        det_clr = 1'b1;
        if (win_vld) state_nxt = SHIFT;
      end
      SHIFT: begin
        det_clr = (bit_cnt == '0);
        if (bit_cnt == BCW'(DW)) state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      word    <= '0;
      bit_cnt <= '0;
      gnt_q   <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        word    <= bus.data[win_idx];
        ch_q    <= win_idx;
        gnt_q   <= NCH'(1) << win_idx;
        cnt_q   <= '0;
        bit_cnt <= '0;
      end
      if (state == SHIFT) begin
        bit_cnt <= bit_cnt + BCW'(1);
        if (bit_cnt != '0) word <= word << 1;
      end
      if ((state == SHIFT || state == FLUSH) && det_z && cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
      if (state == DONE) gnt_q <= '0;
    end
  end

  seq_det_1001 u_det (
    .clk (clk),
    .rst (rst),
    .clr (det_clr),
    .w   (word[DW-1]),
    .z   (det_z)
  );

  assign bus.gnt     = gnt_q;
  assign bus.ack     = (state == DONE) ? gnt_q : '0;
  assign bus.res_cnt = cnt_q;
  assign bus.res_ch  = ch_q;
  assign bus.busy    = (state != IDLE);

endmodule
